// File: rtl/ctx_seq_pkg.sv
// Shared types and constants for the register-context save/restore sequencer.
package ctx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } ctx_state_e;

  localparam int         NREGS    = 32;
  localparam logic [4:0] IDX_LAST = 5'd31;
  localparam int         CTX_W    = 2;

endpackage

// File: rtl/ctx_shadow_ram.sv
// Shadow banks for saved register contexts: one synchronous write port,
// one combinational read port, and a per-bank "holds a saved context" bit.
module ctx_shadow_ram
  import ctx_seq_pkg::*;
#(
  parameter int NUM_CTX = 3,
  parameter int DW      = 32,
  parameter int AW      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CTX_W-1:0]   wr_bank,
  input  logic [AW-1:0]      wr_idx,
  input  logic [DW-1:0]      wr_data,
  input  logic               set_valid,
  input  logic [CTX_W-1:0]   rd_bank,
  input  logic [AW-1:0]      rd_idx,
  output logic [DW-1:0]      rd_data,
  output logic [NUM_CTX-1:0] valid
);

  localparam int DEPTH  = NUM_CTX * (2 ** AW);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DW-1:0]          mem_q [DEPTH];
  logic [NUM_CTX-1:0]     valid_q;
  logic [CTX_W+AW-1:0]    wr_full;
  logic [CTX_W+AW-1:0]    rd_full;
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;

  // Bank number forms the upper address bits; banks >= NUM_CTX never reach here.
  assign wr_full = {wr_bank, wr_idx};
  assign rd_full = {rd_bank, rd_idx};
  assign wr_addr = wr_full[ADDR_W-1:0];
  assign rd_addr = rd_full[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[wr_bank] <= 1'b1;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/reg_ctx_sequencer.sv
// Serial register-file context save/restore engine (one word per cycle).
// Define CTX_SEQ_CHECKSUM_EN to add per-bank XOR checksums and the chk_err output.
module reg_ctx_sequencer
  import ctx_seq_pkg::*;
#(
  parameter int NUM_CTX = 3,
  parameter int DW      = 32,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req,
  input  logic          restore_req,
  input  logic [1:0]    ctx_sel,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rf_rd_num,
  input  logic [DW-1:0] rf_rd_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_w_num,
  output logic [DW-1:0] rf_din
`ifdef CTX_SEQ_CHECKSUM_EN
  ,
  output logic          chk_err
`endif
);

  ctx_state_e         state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [CTX_W-1:0]   bank_q, bank_d;
  logic               err_q, err_d;
  logic [NUM_CTX-1:0] bank_valid;
  logic [3:0]         valid_pad;
  logic               ctx_ok;
  logic               last_word;
  logic [DW-1:0]      shadow_rd;

  ctx_shadow_ram #(
    .NUM_CTX (NUM_CTX),
    .DW      (DW),
    .AW      (AW)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (state_q == SAVE),
    .wr_bank   (bank_q),
    .wr_idx    (idx_q),
    .wr_data   (rf_rd_data),
    .set_valid (state_q == SAVE && last_word),
    .rd_bank   (bank_q),
    .rd_idx    (idx_q),
    .rd_data   (shadow_rd),
    .valid     (bank_valid)
  );

  assign ctx_ok    = ({1'b0, ctx_sel} < 3'(NUM_CTX));
  assign last_word = (idx_q == IDX_LAST);

  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_CTX-1:0]   = bank_valid;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous restore request is dropped without an error.
        if (save_req) begin
          if (ctx_ok) begin
            state_d = SAVE;
            bank_d  = ctx_sel;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (restore_req) begin
          if (ctx_ok && valid_pad[ctx_sel]) begin
            state_d = RESTORE;
            bank_d  = ctx_sel;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SAVE, RESTORE: begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bank_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bank_q  <= bank_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign rf_rd_num = idx_q;
  // Register 0 is hard-wired zero, so the restore pass skips writing it.
  assign rf_we     = (state_q == RESTORE) && (idx_q != '0);
  assign rf_w_num  = idx_q;
  assign rf_din    = (state_q == RESTORE) ? shadow_rd : '0;

`ifdef CTX_SEQ_CHECKSUM_EN
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] chk_q [NUM_CTX];
  logic          chk_mis_q;
  logic [DW-1:0] word;

  assign word = (state_q == SAVE) ? rf_rd_data : shadow_rd;

  always_comb begin
    acc_d = acc_q;
    if (state_q == SAVE || state_q == RESTORE) begin
      acc_d = ((idx_q == '0) ? '0 : acc_q) ^ word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      chk_mis_q <= 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
        chk_q[i] <= '0;
      end
    end else begin
      acc_q     <= acc_d;
      chk_mis_q <= (state_q == RESTORE && last_word) ? (acc_d != chk_q[bank_q]) : 1'b0;
      if (state_q == SAVE && last_word) begin
        chk_q[bank_q] <= acc_d;
      end
    end
  end

  assign chk_err = (state_q == DONE) && chk_mis_q;
`endif

endmodule
